// File: rtl/lenet_batch_ctrl_pkg.sv
// Shared types for the LeNet frame sequencer.
//   state_e : sequencer FSM states
//   MODE_*  : run-mode encodings on the mode port (3 is reserved and runs as SINGLE)
//   res_t   : one buffered result {frame index, predicted digit, reference label}
package lenet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_BATCH  = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

  // Field widths of a stored result; these match the default DIGIT_W/CNT_W of the top.
  localparam int unsigned RES_DIGIT_W = 6;
  localparam int unsigned RES_CNT_W   = 16;

  typedef struct packed {
    logic [RES_CNT_W-1:0]   idx;
    logic [RES_DIGIT_W-1:0] digit;
    logic [RES_DIGIT_W-1:0] label;
  } res_t;

endpackage

// File: rtl/lenet_batch_ctrl_if.sv
// Result stream from the sequencer to its consumer.
//   res_valid : head entry present
//   res_ready : consumer pops when res_valid & res_ready
//   res_idx/res_digit/res_label : head entry fields (0 while empty)
// master = sequencer side, slave = consumer side.
interface lenet_batch_ctrl_if #(
  parameter int unsigned DIGIT_W = 6,
  parameter int unsigned CNT_W   = 16
);

  logic               res_valid;
  logic               res_ready;
  logic [CNT_W-1:0]   res_idx;
  logic [DIGIT_W-1:0] res_digit;
  logic [DIGIT_W-1:0] res_label;

  modport master (
    output res_valid, res_idx, res_digit, res_label,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_idx, res_digit, res_label,
    output res_ready
  );

endinterface

// File: rtl/lenet_batch_ctrl_res_fifo.sv
// Synchronous result FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (same effect as rst)
//   push, din  : write request and data; accepted when not full or when popping
//   pop        : read request; ignored while empty
//   dout       : head entry, driven 0 while empty
//   count      : number of stored entries
//   full/empty : status flags
// DEPTH must be a power of two (pointers wrap naturally).
module lenet_res_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Pop is gated by empty, so a push+pop on an empty FIFO just stores the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/lenet_batch_ctrl.sv
// Frame sequencer for the LeNet chain (source -> src_rom -> lenet -> text_lcd).
// Issues one frame_go per frame, waits for lenet's frame_ready, scores the digit
// against the label and queues {idx,digit,label} for a consumer.
//   clk, rst            : clock, synchronous active-high reset
//   start, stop, mode   : run control (SINGLE / BATCH / CONT)
//   frame_go            : 1-cycle pulse to the upstream source
//   frame_ready, digit_in, label_in : lenet result handshake
//   res                 : result stream (master side)
//   frame_cnt, hit_cnt  : frames completed / correct this run
//   busy, done, timeout_err : run status levels
module lenet_batch_ctrl
  import lenet_pkg::*;
#(
  parameter int unsigned DIGIT_W    = 6,
  parameter int unsigned N_FRAMES   = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 2**20,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [1:0]                 mode,
  output logic                       frame_go,
  input  logic                       frame_ready,
  input  logic [DIGIT_W-1:0]         digit_in,
  input  logic [DIGIT_W-1:0]         label_in,
  lenet_batch_ctrl_if.master         res,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  res_t             push_data;
  res_t             head;
  logic             fifo_push;
  logic             fifo_clr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             pop_eff;
  logic             slot_free;

  assign push_data = '{idx:   RES_CNT_W'(frame_cnt_q),
                       digit: RES_DIGIT_W'(digit_in),
                       label: RES_DIGIT_W'(label_in)};

  lenet_res_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (push_data),
    .pop   (res.res_ready),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A frame is only launched when its result is guaranteed a slot, counting
  // the pop that retires at this same edge.
  assign pop_eff   = res.res_ready && !fifo_empty;
  assign slot_free = (fifo_count - CW'(pop_eff)) < CW'(FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    wd_d        = wd_q;
    frame_go    = 1'b0;
    fifo_push   = 1'b0;
    fifo_clr    = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          fifo_clr    = 1'b1;
          frame_cnt_d = '0;
          hit_cnt_d   = '0;
          wd_d        = '0;
          mode_d      = mode;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (slot_free) begin
          frame_go = 1'b1;
          wd_d     = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (frame_ready) begin
          fifo_push   = !fifo_full;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          hit_cnt_d   = hit_cnt_q + CNT_W'(digit_in == label_in);
          case (mode_q)
            MODE_BATCH: state_d = (frame_cnt_d == CNT_W'(N_FRAMES)) ? DONE : ISSUE;
            MODE_CONT:  state_d = stop ? DONE : ISSUE;
            default:    state_d = DONE;
          endcase
        end else if (wd_q == WD_W'(TIMEOUT - 2)) begin
          // Leave on the edge where the watchdog would reach TIMEOUT-1.
          state_d = ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_SINGLE;
      frame_cnt_q <= '0;
      hit_cnt_q   <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      wd_q        <= wd_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign hit_cnt     = hit_cnt_q;
  assign busy        = (state_q == ISSUE) || (state_q == WAIT);
  assign done        = (state_q == DONE);
  assign timeout_err = (state_q == ERR);

  assign res.res_valid = !fifo_empty;
  assign res.res_idx   = CNT_W'(head.idx);
  assign res.res_digit = DIGIT_W'(head.digit);
  assign res.res_label = DIGIT_W'(head.label);

endmodule
